// File: rtl/game_ram_sequencer.sv
// game_ram_sequencer
//   Owns the shared 32x10 game RAM and runs the round sequence
//   IDLE -> P1 (player1 stores symbols) -> P2 (player2 replays, each entry
//   read back and compared) -> RESULT. Drives every RAM port. Produces the
//   score and status flags for the LED/HEX display.
// Ports
//   clock, resetn          system clock, async active-low reset
//   done_req               1-cycle pulse, advance round
//   p1_valid/p1_data       player1 symbol strobe/data, p1_ready = room left in P1
//   p2_valid/p2_data       player2 guess strobe/data, p2_ready = expected latched
//   ram_addr/data/wren     registered RAM controls, ram_q = RAM read data
//   state                  0 IDLE, 1 P1, 2 P2, 3 RESULT
//   len/idx/score          stored / compared / matched counts (AW+1 bits)
//   overflow               sticky, symbol offered while RAM full
//   game_over              state == RESULT
module game_ram_sequencer #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 10
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          done_req,
   input  logic          p1_valid,
   input  logic [DW-1:0] p1_data,
   output logic          p1_ready,
   input  logic          p2_valid,
   input  logic [DW-1:0] p2_data,
   output logic          p2_ready,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q,
   output logic [1:0]    state,
   output logic [AW:0]   len,
   output logic [AW:0]   idx,
   output logic [AW:0]   score,
   output logic          overflow,
   output logic          game_over
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_P1   = 2'd1;
   localparam logic [1:0] S_P2   = 2'd2;
   localparam logic [1:0] S_RES  = 2'd3;
   localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

   // done_pend: done_req arrived together with an accepted write; the write
   // cycle is finished in P1 before moving on, so ram_wren never shows in P2.
   logic          done_pend;
   // Read pipeline: [0] = address on the bus, [1] = RAM sampled it, ram_q valid.
   logic [1:0]    vld_pipe;
   logic [DW-1:0] expected;
   logic          wr_ok, cmp_ok;
   logic [AW:0]   idx_inc;

   assign p1_ready  = (state == S_P1) && !done_pend && (len < FULL);
   assign wr_ok     = p1_ready && p1_valid;
   assign cmp_ok    = (state == S_P2) && p2_valid && p2_ready;
   assign idx_inc   = idx + 1'b1;
   assign game_over = (state == S_RES);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         len       <= '0;
         idx       <= '0;
         score     <= '0;
         ram_addr  <= '0;
         ram_data  <= '0;
         ram_wren  <= 1'b0;
         p2_ready  <= 1'b0;
         overflow  <= 1'b0;
         done_pend <= 1'b0;
         vld_pipe  <= '0;
         expected  <= '0;
      end else begin
         ram_wren <= 1'b0;
         vld_pipe <= {vld_pipe[0], 1'b0};
         case (state)
            S_IDLE: begin
               if (done_req) begin
                  state     <= S_P1;
                  len       <= '0;
                  idx       <= '0;
                  score     <= '0;
                  overflow  <= 1'b0;
                  done_pend <= 1'b0;
               end
            end
            S_P1: begin
               if (wr_ok) begin
                  ram_wren <= 1'b1;
                  ram_addr <= len[AW-1:0];
                  ram_data <= p1_data;
                  len      <= len + 1'b1;
               end else if (p1_valid && !done_pend && len == FULL) begin
                  overflow <= 1'b1;
               end
               if (done_pend || (done_req && !wr_ok && len != '0)) begin
                  // enter P2 and issue the read of entry 0 in its first cycle
                  done_pend   <= 1'b0;
                  state       <= S_P2;
                  ram_addr    <= idx[AW-1:0];
                  vld_pipe[0] <= 1'b1;
               end else if (done_req && wr_ok) begin
                  done_pend <= 1'b1;
               end else if (done_req) begin
                  state <= S_RES;        // nothing stored, nothing to replay
               end
            end
            S_P2: begin
               if (vld_pipe[1]) begin
                  expected <= ram_q;
                  p2_ready <= 1'b1;
               end
               if (cmp_ok) begin
                  p2_ready <= 1'b0;
                  idx      <= idx_inc;
                  if (p2_data == expected) score <= score + 1'b1;
                  if (idx_inc == len || done_req) begin
                     state <= S_RES;
                  end else begin
                     ram_addr    <= idx_inc[AW-1:0];
                     vld_pipe[0] <= 1'b1;
                  end
               end else if (done_req) begin
                  state    <= S_RES;
                  p2_ready <= 1'b0;
                  vld_pipe <= '0;
               end
            end
            default: begin
               p2_ready <= 1'b0;
               vld_pipe <= '0;
               if (done_req) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
